// File: rtl/cp0_pkg.sv
// Coprocessor 0 constants: register numbers, field positions, exception
// codes and helpers that pack the sparse SR/Cause fields into 32-bit words.
package cp0_pkg;

    localparam logic [4:0] CP0_SR       = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID_NUM = 5'd15;

    localparam int SR_IE       = 0;
    localparam int SR_EXL      = 1;
    localparam int SR_IM_LO    = 10;
    localparam int SR_IM_HI    = 15;
    localparam int CAUSE_BD    = 31;
    localparam int CAUSE_IP_LO = 10;
    localparam int CAUSE_IP_HI = 15;
    localparam int CAUSE_EC_LO = 2;
    localparam int CAUSE_EC_HI = 6;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] CP0_PRID    = 32'h2020_1216;
    localparam logic [31:0] CP0_HANDLER = 32'h0000_4180;

    function automatic logic [31:0] pack_sr(input logic [5:0] im,
                                            input logic exl, input logic ie);
        logic [31:0] w;
        w = '0;
        w[SR_IM_HI:SR_IM_LO] = im;
        w[SR_EXL]            = exl;
        w[SR_IE]             = ie;
        return w;
    endfunction

    function automatic logic [31:0] pack_cause(input logic bd, input logic [5:0] ip,
                                               input logic [4:0] ec);
        logic [31:0] w;
        w = '0;
        w[CAUSE_BD]                = bd;
        w[CAUSE_IP_HI:CAUSE_IP_LO] = ip;
        w[CAUSE_EC_HI:CAUSE_EC_LO] = ec;
        return w;
    endfunction

endpackage

// File: rtl/cp0_if.sv
// M-stage to CP0 bus: mfc0/mtc0 access, victim info, interrupt lines and
// the exception-entry/EPC results returned to the pipeline.
interface cp0_if;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        We;
    logic [31:0] PC;
    logic        BD;
    logic [4:0]  ExcCode;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        IntExc;
    logic [31:0] DOut;
    logic [31:0] EPCOut;

    modport master (
        output A1, A2, DIn, We, PC, BD, ExcCode, HWInt, EXLClr,
        input  IntExc, DOut, EPCOut
    );

    modport slave (
        input  A1, A2, DIn, We, PC, BD, ExcCode, HWInt, EXLClr,
        output IntExc, DOut, EPCOut
    );
endinterface

// File: rtl/cp0.sv
// Coprocessor 0: SR/Cause/EPC/PRId, interrupt vs. exception arbitration and
// same-cycle exception-entry signalling to the pipeline.
module cp0
    import cp0_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    cp0_if.slave  bus
);

    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exccode;
    logic [31:0] r_epc;

    logic        w_int_req;
    logic        w_exc_req;
    logic        w_int_exc;
    logic [31:0] w_victim;
    logic        w_wr_sr;
    logic        w_wr_epc;

    // Reset gates requests explicitly; IE=0 alone would not mask exceptions.
    assign w_int_req = (|(bus.HWInt & r_im)) & r_ie & ~r_exl & ~reset;
    assign w_exc_req = (bus.ExcCode != EXC_INT) & ~r_exl & ~reset;
    assign w_int_exc = w_int_req | w_exc_req;
    assign bus.IntExc = w_int_exc;

    // A delay-slot victim restarts at its branch; PC=0 wraps by design.
    assign w_victim = (bus.BD ? (bus.PC - 32'd4) : bus.PC) & 32'hFFFF_FFFC;

    assign w_wr_sr  = bus.We & ~w_int_exc & (bus.A2 == CP0_SR);
    assign w_wr_epc = bus.We & ~w_int_exc & (bus.A2 == CP0_EPC);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_im      <= '0;
            r_exl     <= 1'b0;
            r_ie      <= 1'b0;
            r_bd      <= 1'b0;
            r_ip      <= '0;
            r_exccode <= '0;
            r_epc     <= '0;
        end else begin
            r_ip <= bus.HWInt;
            if (w_int_exc) begin
                r_exl     <= 1'b1;
                r_bd      <= bus.BD;
                r_exccode <= w_int_req ? EXC_INT : bus.ExcCode;
                r_epc     <= w_victim;
            end else begin
                if (w_wr_sr) begin
                    r_im  <= bus.DIn[SR_IM_HI:SR_IM_LO];
                    r_exl <= bus.DIn[SR_EXL];
                    r_ie  <= bus.DIn[SR_IE];
                end
                if (w_wr_epc)
                    r_epc <= bus.DIn & 32'hFFFF_FFFC;
                // Placed after the SR write so eret wins the EXL bit.
                if (bus.EXLClr)
                    r_exl <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.DOut = '0;
        case (bus.A1)
            CP0_SR:       bus.DOut = pack_sr(r_im, r_exl, r_ie);
            CP0_CAUSE:    bus.DOut = pack_cause(r_bd, r_ip, r_exccode);
            CP0_EPC:      bus.DOut = r_epc;
            CP0_PRID_NUM: bus.DOut = CP0_PRID;
            default:      bus.DOut = '0;
        endcase
    end

    assign bus.EPCOut = r_epc;

endmodule
